// File: rtl/operand_sender_if.sv
// Operand sender bus: start/abort control, the two operands, the four-phase
// request/confirm handshake toward the consumer, and the status outputs.
interface operand_sender_if #(
    parameter int unsigned WIDTH = 7
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] dataP;
    logic [WIDTH-1:0] dataQ;
    logic             confirm;
    logic             request;
    logic [WIDTH-1:0] outData;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       state;

    // Sender side: consumes control/operands/confirm, drives handshake and status.
    modport master (
        input  start, abort, dataP, dataQ, confirm,
        output request, outData, busy, done, error, state
    );

    // Environment side: the loader/controller plus the downstream consumer.
    modport slave (
        output start, abort, dataP, dataQ, confirm,
        input  request, outData, busy, done, error, state
    );
endinterface

// File: rtl/operand_sender.sv
// Sends two captured operands, P then Q, to a consumer over a four-phase
// request/confirm handshake. Each wait state carries an optional timeout that
// parks the block in ERR until abort.
module operand_sender #(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    operand_sender_if.master bus
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReqP = 3'd1,
        StRelP = 3'd2,
        StReqQ = 3'd3,
        StRelQ = 3'd4,
        StDone = 3'd5,
        StErr  = 3'd6
    } state_e;

    localparam bit          TimeoutEn = (TIMEOUT != 0);
    localparam int unsigned CntW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Last count value before the timeout fires; unused when the timeout is off.
    localparam logic [CntW-1:0] CntMax = TimeoutEn ? CntW'(TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             req_q, req_d;

    // State register plus the registered handshake outputs and Q holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            q_q     <= '0;
            out_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            out_q   <= out_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic: abort first, then per-state exit, then the timeout.
    always_comb begin
        logic waiting;
        logic exit_ok;
        state_d = state_q;
        cnt_d   = cnt_q;
        waiting = 1'b0;
        exit_ok = 1'b0;

        if (bus.abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (bus.start) state_d = StReqP;
                StReqP: begin
                    waiting = 1'b1;
                    exit_ok = bus.confirm;
                    if (exit_ok) state_d = StRelP;
                end
                StRelP: begin
                    waiting = 1'b1;
                    exit_ok = !bus.confirm;
                    if (exit_ok) state_d = StReqQ;
                end
                StReqQ: begin
                    waiting = 1'b1;
                    exit_ok = bus.confirm;
                    if (exit_ok) state_d = StRelQ;
                end
                StRelQ: begin
                    waiting = 1'b1;
                    exit_ok = !bus.confirm;
                    if (exit_ok) state_d = StDone;
                end
                StDone:  state_d = StIdle;
                StErr:   state_d = StErr;
                // Unused code 7 recovers to idle.
                default: state_d = StIdle;
            endcase

            // The exit condition wins over a timeout in the same cycle.
            if (TimeoutEn && waiting && !exit_ok && (cnt_q == CntMax)) begin
                state_d = StErr;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (TimeoutEn && waiting) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Registered handshake values derived from the transition being taken.
    always_comb begin
        q_d   = q_q;
        out_d = out_q;
        if ((state_q == StIdle) && (state_d == StReqP)) begin
            q_d   = bus.dataQ;
            out_d = bus.dataP;
        end
        if ((state_q == StRelP) && (state_d == StReqQ)) begin
            out_d = q_q;
        end
        req_d = (state_d == StReqP) || (state_d == StReqQ);
    end

    // Status outputs decoded from the current state.
    always_comb begin
        bus.request = req_q;
        bus.outData = out_q;
        bus.busy    = (state_q != StIdle);
        bus.done    = (state_q == StDone);
        bus.error   = (state_q == StErr);
        bus.state   = state_q;
    end

endmodule

// File: tb/tb_operand_sender.sv
// Bench for operand_sender: directed handshake scenarios plus randomized
// transfers checked against a queue-based consumer model.
module tb_operand_sender;

    localparam int unsigned W  = 7;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic reset;

    operand_sender_if #(.WIDTH(W)) bus ();

    operand_sender #(
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int passed    = 0;
    int done_seen = 0;

    // Count done pulses mid-cycle, away from the active edge.
    always @(negedge clk) if (bus.done === 1'b1) done_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W+7:0] outs;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.confirm = 1'b0;
        bus.dataP   = '0;
        bus.dataQ   = '0;
        #2;
        outs = {bus.request, bus.outData, bus.busy, bus.done, bus.error, bus.state};
        checks++;
        if (outs !== '0) $display("FAIL reset_initial: got %h want 0", outs);
        else passed++;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        outs = {bus.request, bus.outData, bus.busy, bus.done, bus.error, bus.state};
        checks++;
        if (outs !== '0) $display("FAIL reset_idle_after_release: got %h want 0", outs);
        else passed++;
    endtask

    task automatic test_normal();
        logic [2:0] seq [7];
        logic [2:0] exp_seq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        int d0;
        int errs;
        d0   = done_seen;
        errs = 0;
        bus.dataP = 7'h2A;
        bus.dataQ = 7'h55;
        seq[0] = bus.state;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        seq[1] = bus.state;
        checks++;
        if (bus.request !== 1'b1 || bus.outData !== 7'h2A)
            $display("FAIL normal_req_p: req=%b data=%h want req=1 data=2a", bus.request,
                     bus.outData);
        else passed++;
        bus.confirm = 1'b1;
        step();
        seq[2] = bus.state;
        errs += int'(bus.error);
        bus.confirm = 1'b0;
        step();
        seq[3] = bus.state;
        checks++;
        if (bus.request !== 1'b1 || bus.outData !== 7'h55)
            $display("FAIL normal_req_q: req=%b data=%h want req=1 data=55", bus.request,
                     bus.outData);
        else passed++;
        bus.confirm = 1'b1;
        step();
        seq[4] = bus.state;
        errs += int'(bus.error);
        bus.confirm = 1'b0;
        step();
        seq[5] = bus.state;
        checks++;
        if (bus.done !== 1'b1) $display("FAIL normal_done_high: got %b want 1", bus.done);
        else passed++;
        step();
        seq[6] = bus.state;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (seq[i] !== exp_seq[i])
                $display("FAIL normal_state_seq[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]);
            else passed++;
        end
        step();
        checks++;
        if (done_seen - d0 !== 1) $display("FAIL normal_done_count: got %0d want 1", done_seen - d0);
        else passed++;
        checks++;
        if (errs !== 0) $display("FAIL normal_error: got %0d error cycles want 0", errs);
        else passed++;
    endtask

    task automatic test_capture();
        bus.dataP = 7'h2A;
        bus.dataQ = 7'h55;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.dataP = 7'h7F;
        bus.dataQ = 7'h00;
        step();
        checks++;
        if (bus.outData !== 7'h2A) $display("FAIL capture_p: got %h want 2a", bus.outData);
        else passed++;
        bus.confirm = 1'b1;
        step();
        checks++;
        if (bus.outData !== 7'h2A) $display("FAIL capture_p_rel: got %h want 2a", bus.outData);
        else passed++;
        bus.confirm = 1'b0;
        step();
        checks++;
        if (bus.outData !== 7'h55) $display("FAIL capture_q: got %h want 55", bus.outData);
        else passed++;
        bus.confirm = 1'b1;
        step();
        bus.confirm = 1'b0;
        step();
        step();
    endtask

    // Randomized transfers: the model is a FIFO of operands the consumer must
    // see, in order, plus one expected done per accepted start.
    task automatic test_random();
        logic [W-1:0] expq [$];
        logic [W-1:0] want;
        int d0;
        int n;
        localparam int Transfers = 20;
        d0 = done_seen;
        for (int t = 0; t < Transfers; t++) begin
            bus.dataP = W'($urandom_range(0, 127));
            bus.dataQ = W'($urandom_range(0, 127));
            expq.push_back(bus.dataP);
            expq.push_back(bus.dataQ);
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            bus.dataP = W'($urandom);
            bus.dataQ = W'($urandom);
            for (int op = 0; op < 2; op++) begin
                n = 0;
                while (bus.request !== 1'b1 && n < 8) begin
                    step();
                    n++;
                end
                want = expq.pop_front();
                checks++;
                if (bus.request !== 1'b1 || bus.outData !== want)
                    $display("FAIL random_offer[%0d.%0d]: req=%b data=%h want req=1 data=%h",
                             t, op, bus.request, bus.outData, want);
                else passed++;
                repeat ($urandom_range(0, 4)) begin
                    bus.start = 1'($urandom_range(0, 1));
                    step();
                end
                bus.start   = 1'b0;
                bus.confirm = 1'b1;
                step();
                n = 0;
                while (bus.request !== 1'b0 && n < 8) begin
                    step();
                    n++;
                end
                repeat ($urandom_range(0, 4)) begin
                    bus.start = 1'($urandom_range(0, 1));
                    step();
                end
                bus.start   = 1'b0;
                bus.confirm = 1'b0;
                step();
            end
            step();
            step();
            checks++;
            if (bus.state !== 3'd0 || bus.request !== 1'b0)
                $display("FAIL random_idle[%0d]: state=%0d req=%b want state=0 req=0", t,
                         bus.state, bus.request);
            else passed++;
        end
        checks++;
        if (done_seen - d0 !== Transfers)
            $display("FAIL random_done_count: got %0d want %0d", done_seen - d0, Transfers);
        else passed++;
    endtask

    task automatic test_timeout();
        int hi;
        bus.dataP = 7'h13;
        bus.dataQ = 7'h31;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        hi = 0;
        while (bus.request === 1'b1 && hi < 40) begin
            hi++;
            step();
        end
        checks++;
        if (hi !== int'(TO)) $display("FAIL timeout_req_cycles: got %0d want %0d", hi, TO);
        else passed++;
        step();
        step();
        checks++;
        if (bus.state !== 3'd6 || bus.error !== 1'b1 || bus.busy !== 1'b1 ||
            bus.request !== 1'b0 || bus.outData !== 7'h13)
            $display("FAIL timeout_err: state=%0d err=%b busy=%b req=%b data=%h want 6 1 1 0 13",
                     bus.state, bus.error, bus.busy, bus.request, bus.outData);
        else passed++;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.error !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL timeout_abort: state=%0d err=%b busy=%b want 0 0 0", bus.state,
                     bus.error, bus.busy);
        else passed++;
    endtask

    task automatic test_boundary();
        bus.dataP = 7'h0F;
        bus.dataQ = 7'h70;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (TO - 1) step();
        bus.confirm = 1'b1;
        step();
        checks++;
        if (bus.state !== 3'd2 || bus.error !== 1'b0)
            $display("FAIL boundary_exit_wins: state=%0d err=%b want 2 0", bus.state, bus.error);
        else passed++;
        bus.confirm = 1'b0;
        step();
        bus.confirm = 1'b1;
        step();
        bus.confirm = 1'b0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        logic [W+7:0] outs;
        bus.dataP = 7'h66;
        bus.dataQ = 7'h19;
        bus.start = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.confirm = 1'b1;
        step();
        bus.confirm = 1'b0;
        step();
        checks++;
        if (bus.state !== 3'd3) $display("FAIL async_reach_req_q: got %0d want 3", bus.state);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        outs = {bus.request, bus.outData, bus.busy, bus.done, bus.error, bus.state};
        checks++;
        if (outs !== '0) $display("FAIL async_reset_immediate: got %h want 0", outs);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_abort_rel_p();
        int d0;
        d0 = done_seen;
        bus.dataP = 7'h44;
        bus.dataQ = 7'h22;
        bus.start = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.confirm = 1'b1;
        step();
        bus.abort   = 1'b1;
        bus.confirm = 1'b0;
        step();
        bus.abort = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.request !== 1'b0 || bus.outData !== 7'h44)
            $display("FAIL abort_rel_p: state=%0d req=%b data=%h want 0 0 44", bus.state,
                     bus.request, bus.outData);
        else passed++;
        step();
        step();
        checks++;
        if (done_seen - d0 !== 0) $display("FAIL abort_no_done: got %0d want 0", done_seen - d0);
        else passed++;
    endtask

    task automatic test_collisions();
        int d0;
        d0 = done_seen;
        bus.dataP = 7'h01;
        bus.dataQ = 7'h02;
        bus.start = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.state !== 3'd1 || bus.outData !== 7'h01)
            $display("FAIL collide_req_p: state=%0d data=%h want 1 01", bus.state, bus.outData);
        else passed++;
        bus.confirm = 1'b1;
        step();
        bus.confirm = 1'b0;
        step();
        bus.confirm = 1'b1;
        step();
        bus.confirm = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.request !== 1'b0)
            $display("FAIL collide_done_start: state=%0d req=%b want 0 0", bus.state,
                     bus.request);
        else passed++;
        step();
        checks++;
        if (done_seen - d0 !== 1) $display("FAIL collide_done_count: got %0d want 1", done_seen - d0);
        else passed++;

        // start and abort together in idle: abort is ignored there.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.state !== 3'd1 || bus.request !== 1'b1)
            $display("FAIL start_abort_idle: state=%0d req=%b want 1 1", bus.state, bus.request);
        else passed++;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.request !== 1'b0)
            $display("FAIL abort_req_p: state=%0d req=%b want 0 0", bus.state, bus.request);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_capture();
        test_random();
        test_timeout();
        test_boundary();
        test_async_reset();
        test_abort_rel_p();
        test_collisions();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
